// File: rtl/glb_write_sched.sv
// GLB write-port scheduler: round-robin arbitration between two streaming loaders,
// one burst per grant, with wrapping address generation and column-id tagging.
module glb_write_sched #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_COL     = 8,
  parameter int BUFFER_SIZE = 512,
  localparam int AW  = $clog2(BUFFER_SIZE),
  localparam int IDW = $clog2(NUM_COL) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [AW-1:0]         base0,
  input  logic [AW-1:0]         base1,
  input  logic [AW:0]           len0,
  input  logic [AW:0]           len1,
  input  logic [7:0]            ksize0,
  input  logic [7:0]            ksize1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic                  valid0,
  input  logic                  valid1,
  output logic                  ready0,
  output logic                  ready1,
  output logic                  done0,
  output logic                  done1,
  output logic                  glb_we,
  output logic [AW-1:0]         glb_addr,
  output logic [DATA_WIDTH-1:0] glb_data,
  output logic [IDW-1:0]        glb_id,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2} state_t;

  state_t                  state_r, state_s;
  logic                    owner_r, last_r;
  logic                    start_s, win_s, hs_s, sel_valid_s;
  logic [AW-1:0]           addr_r;
  logic [AW:0]             cnt_r, len_r;
  logic [IDW-1:0]          k_r, id_r;
  logic                    glb_we_r, done0_r, done1_r;
  logic [AW-1:0]           glb_addr_r;
  logic [DATA_WIDTH-1:0]   glb_data_r;
  logic [IDW-1:0]          glb_id_r;

  function automatic logic [IDW-1:0] clamp_k(input logic [7:0] k);
    if (k == 8'd0) begin
      return IDW'(1);
    end else if (k > 8'(NUM_COL)) begin
      return IDW'(NUM_COL);
    end else begin
      return k[IDW-1:0];
    end
  endfunction

  // next-state, arbitration and handshake decode
  always_comb begin
    state_s     = state_r;
    start_s     = 1'b0;
    win_s       = owner_r;
    hs_s        = 1'b0;
    sel_valid_s = owner_r ? valid1 : valid0;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          start_s = 1'b1;
          win_s   = ~last_r;
        end else if (req0) begin
          start_s = 1'b1;
          win_s   = 1'b0;
        end else if (req1) begin
          start_s = 1'b1;
          win_s   = 1'b1;
        end else begin
          start_s = 1'b0;
        end
        if (start_s) begin
          state_s = ((win_s ? len1 : len0) == '0) ? DONE : BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        hs_s = sel_valid_s;
        if (hs_s && (cnt_r == len_r - (AW+1)'(1))) begin
          state_s = DONE;
        end else begin
          state_s = BURST;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state, owner and round-robin history (last_r = 1 means port 1 was last served)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      if (start_s) owner_r <= win_s;
      if (state_r == DONE) last_r <= owner_r;
    end
  end

  // burst bookkeeping: next address, word count and next id
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_r <= '0;
      cnt_r  <= '0;
      len_r  <= '0;
      k_r    <= '0;
      id_r   <= '0;
    end else if (start_s) begin
      addr_r <= win_s ? base1 : base0;
      len_r  <= win_s ? len1 : len0;
      k_r    <= clamp_k(win_s ? ksize1 : ksize0);
      cnt_r  <= '0;
      id_r   <= IDW'(1);
    end else if (hs_s) begin
      addr_r <= (addr_r == AW'(BUFFER_SIZE - 1)) ? '0 : addr_r + AW'(1);
      cnt_r  <= cnt_r + (AW+1)'(1);
      id_r   <= (id_r == k_r) ? IDW'(1) : id_r + IDW'(1);
    end
  end

  // registered GLB write port and done pulses; id holds between writes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      glb_we_r   <= 1'b0;
      glb_addr_r <= '0;
      glb_data_r <= '0;
      glb_id_r   <= '0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
    end else begin
      glb_we_r   <= hs_s;
      glb_addr_r <= hs_s ? addr_r : '0;
      glb_data_r <= hs_s ? (owner_r ? data1 : data0) : '0;
      if (hs_s) glb_id_r <= id_r;
      done0_r    <= (state_r == DONE) && !owner_r;
      done1_r    <= (state_r == DONE) && owner_r;
    end
  end

  assign ready0   = (state_r == BURST) && !owner_r;
  assign ready1   = (state_r == BURST) && owner_r;
  assign busy     = (state_r != IDLE);
  assign grant    = (state_r == IDLE) ? 2'b00 : (owner_r ? 2'b10 : 2'b01);
  assign glb_we   = glb_we_r;
  assign glb_addr = glb_addr_r;
  assign glb_data = glb_data_r;
  assign glb_id   = glb_id_r;
  assign done0    = done0_r;
  assign done1    = done1_r;

endmodule

// File: tb/tb_glb_write_sched.sv
// Bench for glb_write_sched: a per-cycle expected trace is built from burst-level
// rules (arbitration, wrap, id cycling, fixed latencies) and compared every cycle.
module tb_glb_write_sched;
  localparam int DW = 16, NCOL = 8, BS = 512, AW = 9, IDW = 4, NC = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, req0, req1, valid0, valid1, ready0, ready1, done0, done1, glb_we, busy;
  logic [AW-1:0] base0, base1, glb_addr;
  logic [AW:0] len0, len1;
  logic [7:0] ksize0, ksize1;
  logic [DW-1:0] data0, data1, glb_data;
  logic [IDW-1:0] glb_id;
  logic [1:0] grant;

  glb_write_sched #(.DATA_WIDTH(DW), .NUM_COL(NCOL), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .base0(base0), .base1(base1),
    .len0(len0), .len1(len1), .ksize0(ksize0), .ksize1(ksize1), .data0(data0), .data1(data1),
    .valid0(valid0), .valid1(valid1), .ready0(ready0), .ready1(ready1), .done0(done0),
    .done1(done1), .glb_we(glb_we), .glb_addr(glb_addr), .glb_data(glb_data),
    .glb_id(glb_id), .grant(grant), .busy(busy));

  int n_tests = 0, n_fail = 0, cyc = 0, last_served = 1;
  bit run = 1'b0;
  int r_req [2][NC], r_val [2][NC], r_dat [2][NC], r_base [2][NC], r_len [2][NC], r_k [2][NC];
  int r_rstn [NC];
  int e_we [NC], e_addr [NC], e_data [NC], e_idw [NC], e_id [NC], e_busy [NC], e_grant [NC];
  int e_ready [2][NC], e_done [2][NC];
  int log_addr [$], log_data [$], log_id [$];

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, c, act, exp);
    end
  endtask

  // One burst: request held t0..ts, sampled at ts, valid pattern over burst cycles.
  task automatic plan(input int p, input int t0, input int ts, input int base, input int len,
                      input int k, input logic [31:0] vpat, input int dst, output int tend);
    int kc, n, c;
    kc = (k == 0) ? 1 : ((k > NCOL) ? NCOL : k);
    for (int i = t0; i <= ts; i++) begin
      r_req[p][i] = 1; r_base[p][i] = base; r_len[p][i] = len; r_k[p][i] = k;
    end
    n = 0;
    c = ts + 1;
    while (n < len) begin
      e_busy[c] = 1; e_grant[c] = p ? 2 : 1; e_ready[p][c] = 1;
      if (vpat[(c - ts - 1) % 32]) begin
        r_val[p][c] = 1; r_dat[p][c] = dst + n;
        e_we[c+1] = 1; e_addr[c+1] = (base + n) % BS; e_data[c+1] = dst + n;
        e_idw[c+1] = (n % kc) + 1;
        n++;
      end else begin
        r_dat[p][c] = 16'hBEEF;
      end
      c++;
    end
    e_busy[c] = 1; e_grant[c] = p ? 2 : 1;
    e_done[p][c+1] = 1;
    tend = c + 1;
    last_served = p;
  endtask

  task automatic plan_both(input int t, input int b0, input int l0, input int k0, input int d0,
                           input int b1, input int l1, input int k1, input int d1, output int tend);
    int e1;
    if (last_served == 1) begin
      plan(0, t, t, b0, l0, k0, 32'hFFFFFFFF, d0, e1);
      plan(1, t, e1, b1, l1, k1, 32'hFFFFFFFF, d1, tend);
    end else begin
      plan(1, t, t, b1, l1, k1, 32'hFFFFFFFF, d1, e1);
      plan(0, t, e1, b0, l0, k0, 32'hFFFFFFFF, d0, tend);
    end
  endtask

  task automatic apply_reset(input int c, input int n, input int clr_end);
    for (int i = c; i < c + n; i++) r_rstn[i] = 0;
    for (int i = c; i <= clr_end; i++) begin
      e_we[i] = 0; e_addr[i] = 0; e_data[i] = 0; e_idw[i] = 0; e_busy[i] = 0; e_grant[i] = 0;
      e_ready[0][i] = 0; e_ready[1][i] = 0; e_done[0][i] = 0; e_done[1][i] = 0;
    end
    last_served = 1;
  endtask

  // per-cycle comparison against the expected trace
  always @(negedge clk) begin
    if (run) begin
      chk("glb_we", cyc, 32'(glb_we), 32'(e_we[cyc]));
      chk("glb_addr", cyc, 32'(glb_addr), 32'(e_addr[cyc]));
      chk("glb_data", cyc, 32'(glb_data), 32'(e_data[cyc]));
      chk("glb_id", cyc, 32'(glb_id), 32'(e_id[cyc]));
      chk("ready0", cyc, 32'(ready0), 32'(e_ready[0][cyc]));
      chk("ready1", cyc, 32'(ready1), 32'(e_ready[1][cyc]));
      chk("done0", cyc, 32'(done0), 32'(e_done[0][cyc]));
      chk("done1", cyc, 32'(done1), 32'(e_done[1][cyc]));
      chk("grant", cyc, 32'(grant), 32'(e_grant[cyc]));
      chk("busy", cyc, 32'(busy), 32'(e_busy[cyc]));
      if (glb_we === 1'b1) begin
        log_addr.push_back(int'(glb_addr));
        log_data.push_back(int'(glb_data));
        log_id.push_back(int'(glb_id));
      end
    end
  end

  initial begin
    int te, hold;
    int pid1 [6] = '{1, 2, 3, 1, 2, 3};
    int pa3 [4] = '{510, 511, 0, 1};
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    base0 = '0; base1 = '0; len0 = '0; len1 = '0; ksize0 = '0; ksize1 = '0;
    data0 = '0; data1 = '0;
    for (int c = 0; c < NC; c++) begin
      r_rstn[c] = (c < 3) ? 0 : 1;
      e_we[c] = 0; e_addr[c] = 0; e_data[c] = 0; e_idw[c] = 0; e_id[c] = 0;
      e_busy[c] = 0; e_grant[c] = 0;
      for (int p = 0; p < 2; p++) begin
        r_req[p][c] = 0; r_val[p][c] = 0; r_dat[p][c] = 0; r_base[p][c] = 0;
        r_len[p][c] = 0; r_k[p][c] = 0; e_ready[p][c] = 0; e_done[p][c] = 0;
      end
    end

    plan(0, 5, 5, 0, 6, 3, 32'hFFFFFFFF, 10, te);        // port 0 only
    apply_reset(15, 2, 16);
    plan_both(20, 100, 2, 2, 20, 200, 2, 5, 30, te);      // contention after reset
    plan_both(30, 300, 2, 3, 40, 400, 2, 1, 50, te);      // contention again
    plan(1, 42, 42, 510, 4, 0, 32'hFFFFFFFF, 50, te);     // wrap, ksize 0
    plan(0, 50, 50, 20, 4, 8, 32'h55555555, 60, te);      // toggling valid
    plan(0, 62, 62, 7, 0, 3, 32'hFFFFFFFF, 0, te);        // zero length
    plan(0, 68, 68, 40, 8, 4, 32'hFFFFFFFF, 70, te);      // aborted by reset
    apply_reset(73, 2, te);
    plan(0, 80, 80, 40, 3, 4, 32'hFFFFFFFF, 90, te);      // restart after reset

    hold = 0;
    for (int c = 0; c < NC; c++) begin
      if (r_rstn[c] == 0) hold = 0;
      if (e_we[c] != 0) hold = e_idw[c];
      e_id[c] = hold;
    end

    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      rstn   = (r_rstn[c] != 0);
      req0   = (r_req[0][c] != 0);  req1   = (r_req[1][c] != 0);
      valid0 = (r_val[0][c] != 0);  valid1 = (r_val[1][c] != 0);
      data0  = DW'(r_dat[0][c]);    data1  = DW'(r_dat[1][c]);
      base0  = AW'(r_base[0][c]);   base1  = AW'(r_base[1][c]);
      len0   = (AW+1)'(r_len[0][c]); len1  = (AW+1)'(r_len[1][c]);
      ksize0 = 8'(r_k[0][c]);       ksize1 = 8'(r_k[1][c]);
      cyc = c;
      run = 1'b1;
    end
    @(posedge clk);
    run = 1'b0;

    chk("write_count", 0, 32'(log_addr.size()), 32'd28);
    if (log_addr.size() >= 28) begin
      for (int i = 0; i < 6; i++) begin
        chk("t1_addr", i, 32'(log_addr[i]), 32'(i));
        chk("t1_data", i, 32'(log_data[i]), 32'(10 + i));
        chk("t1_id", i, 32'(log_id[i]), 32'(pid1[i]));
      end
      for (int i = 0; i < 4; i++) begin
        chk("wrap_addr", i, 32'(log_addr[14+i]), 32'(pa3[i]));
        chk("wrap_id", i, 32'(log_id[14+i]), 32'd1);
      end
      chk("restart_addr", 25, 32'(log_addr[25]), 32'd40);
      chk("restart_id", 25, 32'(log_id[25]), 32'd1);
      chk("restart_id_last", 27, 32'(log_id[27]), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
